// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered N-to-2^N one-hot decoder with a self-stepping, dwell-timed scan mode
module decoder_n_scan #(
   parameter int N     = 3,
   parameter int DWELL = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     inp,
   input  logic             enable,
   input  logic             mode,
   output logic [(1<<N)-1:0] out,
   output logic [N-1:0]     sel,
   output logic             wrap
);
   localparam int M  = 1 << N;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] LAST = DW'(DWELL - 1);

   generate
      if (DWELL < 1) begin : g_bad_dwell
         $error("decoder_n_scan: DWELL must be >= 1");
      end
   endgenerate

   logic [N-1:0]  idx, idx_n, nidx, sel_n;
   logic [DW-1:0] dcnt, dcnt_n;
   logic [M-1:0]  out_n;
   logic          mode_q, wrap_n;

   function automatic logic [M-1:0] onehot(input logic [N-1:0] i);
      return M'(1) << i;
   endfunction

   // next index: wrap by compare against the live range limit, never by overflow
   always_comb nidx = (idx >= inp) ? '0 : idx + 1'b1;

   // next-state and output decode for direct, scan entry, scan step and freeze
   always_comb begin
      idx_n  = idx;
      dcnt_n = dcnt;
      sel_n  = sel;
      out_n  = '0;
      wrap_n = 1'b0;
      if (!mode) begin
         idx_n  = '0;
         dcnt_n = '0;
         sel_n  = enable ? inp : sel;
         out_n  = enable ? onehot(inp) : '0;
      end else if (!mode_q) begin
         idx_n  = '0;
         dcnt_n = '0;
         sel_n  = '0;
         out_n  = enable ? M'(1) : '0;
      end else if (enable) begin
         idx_n  = (dcnt == LAST) ? nidx : idx;
         dcnt_n = (dcnt == LAST) ? '0 : dcnt + 1'b1;
         sel_n  = (dcnt == LAST) ? nidx : sel;
         out_n  = onehot((dcnt == LAST) ? nidx : idx);
         wrap_n = (dcnt == LAST) && (nidx == '0);
      end
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx    <= '0;
         dcnt   <= '0;
         mode_q <= 1'b0;
         out    <= '0;
         sel    <= '0;
         wrap   <= 1'b0;
      end else begin
         idx    <= idx_n;
         dcnt   <= dcnt_n;
         mode_q <= mode;
         out    <= out_n;
         sel    <= sel_n;
         wrap   <= wrap_n;
      end
   end
endmodule

// File: tb/tb_decoder_n_scan.sv
// tb_decoder_n_scan: vector table, scan corner sequences and random run against a behavioural model
module tb_decoder_n_scan;
   localparam int N     = 3;
   localparam int DWELL = 4;

   logic       clk, rst, enable, mode;
   logic [2:0] inp;
   logic [7:0] out;
   logic [2:0] sel;
   logic       wrap;

   int n_chk = 0;
   int n_fail = 0;

   // behavioural model: current index and how many cycles of its dwell have been shown
   int m_idx, m_served, m_modeq, m_out, m_sel, m_wrap;

   typedef struct {
      logic       m, e;
      logic [2:0] i;
      logic [7:0] o;
      logic [2:0] s;
      logic       w;
   } vec_t;
   vec_t vecs[12];

   decoder_n_scan #(.N(N), .DWELL(DWELL)) dut (
      .clk(clk), .rst(rst), .inp(inp), .enable(enable), .mode(mode),
      .out(out), .sel(sel), .wrap(wrap)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_idx = 0; m_served = 0; m_modeq = 0; m_out = 0; m_sel = 0; m_wrap = 0;
   endtask

   task automatic model_step(input int m, input int e, input int i);
      if (m == 0) begin
         m_idx = 0; m_served = 0; m_wrap = 0;
         if (e != 0) begin m_out = 1 << i; m_sel = i; end
         else m_out = 0;
      end else if (m_modeq == 0) begin
         m_idx = 0; m_served = 1; m_sel = 0; m_wrap = 0;
         m_out = (e != 0) ? 1 : 0;
      end else if (e == 0) begin
         m_out = 0; m_wrap = 0;
      end else if (m_served < DWELL) begin
         m_served++; m_out = 1 << m_idx; m_wrap = 0;
      end else begin
         m_idx = (m_idx >= i) ? 0 : m_idx + 1;
         m_served = 1; m_sel = m_idx; m_out = 1 << m_idx;
         m_wrap = (m_idx == 0) ? 1 : 0;
      end
      m_modeq = m;
   endtask

   // drive one cycle at the falling edge, step the model, compare after the rising edge
   task automatic cyc(input logic m, input logic e, input logic [2:0] i);
      @(negedge clk);
      rst = 0; mode = m; enable = e; inp = i;
      model_step(int'(m), int'(e), int'(i));
      @(posedge clk);
      #1;
      chk("model_out", 32'(out), 32'(m_out));
      chk("model_sel", 32'(sel), 32'(m_sel));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
   endtask

   initial begin
      logic rm, re;
      logic [2:0] ri;
      rst = 1; mode = 0; enable = 0; inp = 0;
      model_reset();
      #1;
      chk("reset_out", 32'(out), 0);
      chk("reset_sel", 32'(sel), 0);
      chk("reset_wrap", 32'(wrap), 0);
      repeat (2) @(posedge clk);

      // direct-mode vector table, ending with a scan entry
      vecs[0] = '{1'b0, 1'b1, 3'd5, 8'h20, 3'd5, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 3'd5, 8'h00, 3'd5, 1'b0};
      for (int k = 0; k < 8; k++) begin
         vecs[2+k].m = 1'b0;
         vecs[2+k].e = 1'b1;
         vecs[2+k].i = 3'(k);
         vecs[2+k].o = 8'h01 << k;
         vecs[2+k].s = 3'(k);
         vecs[2+k].w = 1'b0;
      end
      vecs[10] = '{1'b0, 1'b0, 3'd3, 8'h00, 3'd7, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 3'd7, 8'h01, 3'd0, 1'b0};
      for (int k = 0; k < 12; k++) begin
         cyc(vecs[k].m, vecs[k].e, vecs[k].i);
         chk("vec_out", 32'(out), 32'(vecs[k].o));
         chk("vec_sel", 32'(sel), 32'(vecs[k].s));
         chk("vec_wrap", 32'(wrap), 32'(vecs[k].w));
      end

      // full scan: cycle c after entry shows index c/4, single wrap at period 32
      for (int c = 1; c <= 32; c++) begin
         cyc(1, 1, 7);
         chk("full_out", 32'(out), 32'(8'h01 << ((c / 4) % 8)));
         chk("full_wrap", 32'(wrap), (c == 32) ? 1 : 0);
      end

      // short scan over 0..2: wrap every 12 cycles
      for (int c = 1; c <= 24; c++) begin
         cyc(1, 1, 2);
         chk("short_out", 32'(out), 32'(8'h01 << ((c / 4) % 3)));
         chk("short_wrap", 32'(wrap), (c % 12 == 0) ? 1 : 0);
      end

      // freeze on the 2nd dwell cycle of index 3
      cyc(0, 1, 0);
      for (int c = 0; c < 14; c++) cyc(1, 1, 7);
      chk("pre_freeze_out", 32'(out), 32'h08);
      for (int c = 0; c < 5; c++) begin
         cyc(1, 0, 7);
         chk("freeze_out", 32'(out), 0);
         chk("freeze_sel", 32'(sel), 3);
      end
      cyc(1, 1, 7); chk("resume_out1", 32'(out), 32'h08);
      cyc(1, 1, 7); chk("resume_out2", 32'(out), 32'h08);
      cyc(1, 1, 7); chk("resume_next", 32'(out), 32'h10);

      // shrink range while index 5 is showing
      repeat (3) cyc(1, 1, 7);
      cyc(1, 1, 7); chk("shrink_at5", 32'(out), 32'h20);
      repeat (3) cyc(1, 1, 1);
      chk("shrink_hold5", 32'(out), 32'h20);
      for (int k = 0; k < 12; k++) begin
         cyc(1, 1, 1);
         chk("shrink_out", 32'(out), 32'(8'h01 << ((k / 4) % 2)));
         chk("shrink_wrap", 32'(wrap), (k % 8 == 0) ? 1 : 0);
      end
      cyc(1, 1, 1);
      chk("pre_reset_sel", 32'(sel), 1);

      // asynchronous reset between edges, then restart at index 0
      @(negedge clk);
      rst = 1; mode = 1; enable = 1; inp = 7;
      #1;
      chk("async_out", 32'(out), 0);
      chk("async_sel", 32'(sel), 0);
      chk("async_wrap", 32'(wrap), 0);
      model_reset();
      @(posedge clk);
      cyc(1, 1, 7);
      chk("restart_out", 32'(out), 32'h01);
      chk("restart_sel", 32'(sel), 0);
      chk("restart_wrap", 32'(wrap), 0);

      // randomized run against the model
      rm = 1; ri = 7;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(63) == 0) rm = ~rm;
         re = ($urandom_range(7) != 0);
         if ($urandom_range(15) == 0) ri = 3'($urandom_range(7));
         cyc(rm, re, ri);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/decoder_n_scan.md
# decoder_n_scan

Parametrised, registered N-to-2^N one-hot decoder with a self-stepping scan mode. In direct mode it decodes `inp` like the fixed 2-to-4/3-to-8 decoders, but through an output register. In scan mode it walks the active output from index 0 up to a programmable last index, holding each index for a fixed dwell count. It is intended for multiplexed display digit drivers, row strobes and round-robin select lines.

## Interface
Parameters:
- `N`, default 3: select width; output width is 2^N.
- `DWELL`, default 4: clock cycles each index is held in scan mode. Must be ≥1; elaboration error otherwise.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inp`  in  N  direct mode: index to decode. Scan mode: last index of the scan range (0..inp).
- `enable`  in  1  active-high. When low, outputs are forced to zero and the scan state freezes.
- `mode`  in  1  0 = direct, 1 = scan.
- `out`  out  2^N  registered one-hot output, or all-zero.
- `sel`  out  N  registered binary index of the last asserted output.
- `wrap`  out  1  one-cycle pulse when the scan returns to index 0.

## Operation
- Internal state:
  - `idx` (N bits).
  - `dcnt` (max(1, clog2(DWELL)) bits).
  - `mode_q`: `mode` delayed one cycle.
  - All outputs are registers; none is combinational from the inputs.
- Direct mode (`mode`=0), each edge:
  - `enable`=1: `out` ← 1<<`inp`; `sel` ← `inp`.
  - `enable`=0: `out` ← 0; `sel` holds.
  - `wrap` ← 0; `idx` and `dcnt` ← 0.
- Scan entry (edge with `mode`=1 and `mode_q`=0):
  - `idx` ← 0, `dcnt` ← 0, `sel` ← 0, `wrap` ← 0.
  - `out` ← 1 if `enable`, else 0.
  - The entry edge counts as the first dwell cycle of index 0.
- Scan, `enable`=1, `mode_q`=1:
  - If `dcnt` < DWELL−1: `dcnt`++; `out` ← 1<<`idx`; `wrap` ← 0.
  - If `dcnt` = DWELL−1: `dcnt` ← 0; nidx = (`idx` ≥ `inp`) ? 0 : `idx`+1.
    - `idx` ← nidx; `sel` ← nidx; `out` ← 1<<nidx.
    - `wrap` ← (nidx == 0).
- Scan, `enable`=0: `idx`, `dcnt` and `sel` hold; `out` ← 0; `wrap` ← 0. Re-enabling resumes the remaining dwell of the frozen index.
- `inp` is sampled at every step decision. If `inp` drops below the current `idx`, the next step wraps to 0 and pulses `wrap`. If `inp` rises, the scan extends without a restart.
- `inp` = 0 in scan mode: index 0 is held permanently, and `wrap` pulses every DWELL cycles.
- Scan → direct: the direct rules apply from the first edge with `mode`=0.

## Timing
- Reset values: `out`=0, `sel`=0, `wrap`=0, `idx`=0, `dcnt`=0, `mode_q`=0. Reset acts immediately, without waiting for a clock edge.
- Reset mid-scan: all state clears asynchronously. On the first edge after release with `mode`=1, `mode_q`=0 forces scan entry, so the scan restarts at index 0.
- Direct-mode latency: 1 cycle from `inp`/`enable` to `out`/`sel`.
- Scan period with `enable` held high: DWELL × (`inp`+1) cycles. `wrap` is high during exactly one cycle per period: the first cycle of index 0, excluding the scan-entry cycle.
- With DWELL=1, `dcnt` is a constant 0 and the index advances every edge.
- Index arithmetic is N-bit. When `inp` = 2^N−1, nidx from the top index is 0 by the compare rule, not by overflow.

## Test plan
All scenarios use N=3, DWELL=4.
1. Direct decode:
   - `mode`=0, `enable`=1, `inp`=5 → next edge `out`=8'h20, `sel`=5.
   - Then `enable`=0 → `out`=8'h00, `sel`=5.
   - Sweep `inp`=0..7 → `out` = 8'h01..8'h80, each with 1-cycle latency.
2. Full scan:
   - `mode`=1, `enable`=1, `inp`=7 → `out` shows 01,02,04,…,80, each for 4 cycles.
   - Then 01 with `wrap`=1 for one cycle; period 32.
3. Short scan: `inp`=2 → `out` cycles 01,02,04 with 4 cycles each; `wrap` pulses every 12 cycles.
4. Freeze:
   - `enable`=0 for 5 cycles on the 2nd dwell cycle of index 3 → `out`=0 during the freeze; `sel`=3 holds.
   - On re-enable, `out`=8'h08 for the remaining 2 cycles, then 8'h10.
5. Shrink range: while `idx`=5, set `inp`=1 → at the dwell end `out`=8'h01 with `wrap`=1; thereafter 01,02 alternate every 4 cycles.
6. Async reset mid-scan:
   - Assert `rst` between edges → `out`, `sel` and `wrap` read 0 before the next edge.
   - Release with `mode`=1 → first edge `out`=8'h01, `sel`=0, `wrap`=0.
